// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if
// AXI read-address (AR) and read-data (R) channel bundle shared by the arbiter and the AXI slave.
//   master modport: drives ar* and rready; samples arready and the R channel.
//   slave  modport: the opposite directions.
interface axi_rd_arbiter_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter
// Round-robin arbiter merging an instruction-side and a data-side read requester onto one AXI
// read port, with a single transaction outstanding at a time.
//   aclk, areset          : clock, asynchronous active-high reset
//   i_req/i_addr/i_len    : instruction request (size fixed to 4 bytes); i_gnt, i_rvalid, i_rlast
//   d_req/d_addr/d_len/d_size : data request; d_gnt, d_rvalid, d_rlast
//   rd_data               : shared read data (rdata pass-through)
//   axi                   : AXI AR/R channels, master side
module axi_rd_arbiter #(
    parameter logic [3:0] ID_I = 4'd0,
    parameter logic [3:0] ID_D = 4'd1
) (
    input  logic                  aclk,
    input  logic                  areset,

    input  logic                  i_req,
    input  logic [31:0]           i_addr,
    input  logic [3:0]            i_len,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic                  i_rlast,

    input  logic                  d_req,
    input  logic [31:0]           d_addr,
    input  logic [3:0]            d_len,
    input  logic [2:0]            d_size,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic                  d_rlast,

    output logic [31:0]           rd_data,

    axi_rd_arbiter_if.master      axi
);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e      state_q;
    logic        owner_d_q;   // 1: data side owns the current transaction
    logic        last_i_q;    // 1: instruction side was served last
    logic [31:0] addr_q;
    logic [3:0]  len_q;
    logic [2:0]  size_q;
    logic [3:0]  id_q;
    logic        arvalid_q;
    logic        rready_q;

    // Data wins when alone, or on a tie when instruction was served last.
    logic pick_d;
    assign pick_d = d_req && (!i_req || last_i_q);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= StIdle;
            owner_d_q <= 1'b0;
            last_i_q  <= 1'b1;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            id_q      <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_req || d_req) begin
                        owner_d_q <= pick_d;
                        last_i_q  <= !pick_d;
                        addr_q    <= pick_d ? d_addr : i_addr;
                        len_q     <= pick_d ? d_len  : i_len;
                        size_q    <= pick_d ? d_size : 3'b010;
                        id_q      <= pick_d ? ID_D   : ID_I;
                        arvalid_q <= 1'b1;
                        state_q   <= StAddr;
                    end
                end
                StAddr: begin
                    if (axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= StData;
                    end
                end
                StData: begin
                    if (axi.rvalid && axi.rlast) begin
                        rready_q <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    logic ar_hs;
    logic beat;
    assign ar_hs = arvalid_q && axi.arready;
    // rready is high exactly in the data phase, so it also gates routing of stray beats.
    assign beat  = rready_q && axi.rvalid;

    assign axi.arid    = id_q;
    assign axi.araddr  = addr_q;
    assign axi.arlen   = len_q;
    assign axi.arsize  = size_q;
    assign axi.arburst = 2'b01;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

    assign i_gnt    = ar_hs && !owner_d_q;
    assign d_gnt    = ar_hs && owner_d_q;
    assign i_rvalid = beat && !owner_d_q;
    assign d_rvalid = beat && owner_d_q;
    assign i_rlast  = beat && !owner_d_q && axi.rlast;
    assign d_rlast  = beat && owner_d_q && axi.rlast;
    assign rd_data  = axi.rdata;

    // Beats are routed by the latched owner only; rid and rresp are deliberately ignored.
    logic unused_r;
    assign unused_r = ^{axi.rid, axi.rresp};

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter
// Directed bench for axi_rd_arbiter; the bench plays the AXI slave through the interface.
module tb_axi_rd_arbiter;

    logic        aclk = 1'b0;
    logic        areset;
    logic        i_req, d_req;
    logic [31:0] i_addr, d_addr;
    logic [3:0]  i_len, d_len;
    logic [2:0]  d_size;
    logic        i_gnt, i_rvalid, i_rlast;
    logic        d_gnt, d_rvalid, d_rlast;
    logic [31:0] rd_data;

    int checks = 0;
    int errors = 0;

    axi_rd_arbiter_if bus ();

    axi_rd_arbiter dut (
        .aclk     (aclk),
        .areset   (areset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_len    (i_len),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rlast  (i_rlast),
        .d_req    (d_req),
        .d_addr   (d_addr),
        .d_len    (d_len),
        .d_size   (d_size),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rlast  (d_rlast),
        .rd_data  (rd_data),
        .axi      (bus)
    );

    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        areset = 1'b1;
        i_req = 0; d_req = 0; i_addr = 0; d_addr = 0; i_len = 0; d_len = 0; d_size = 0;
        bus.arready = 0; bus.rvalid = 0; bus.rlast = 0; bus.rdata = 0;
        bus.rid = 0; bus.rresp = 0;

        // Reset state
        #12;
        check("rst_arvalid", bus.arvalid, 0);
        check("rst_rready", bus.rready, 0);
        check("rst_i_gnt", i_gnt, 0);
        check("rst_d_gnt", d_gnt, 0);
        check("rst_araddr", bus.araddr, 0);
        check("rst_arid", bus.arid, 0);
        check("arburst", bus.arburst, 2'b01);
        step();
        areset = 1'b0;

        // Tie after reset: data wins first, instruction next
        i_req = 1; i_addr = 32'h0000_1000; i_len = 0;
        d_req = 1; d_addr = 32'h0000_2000; d_len = 0; d_size = 3'b010;
        bus.arready = 1;
        #1 check("tie_idle_arvalid", bus.arvalid, 0);
        step();
        #1;
        check("tie1_arvalid", bus.arvalid, 1);
        check("tie1_arid", bus.arid, 1);
        check("tie1_araddr", bus.araddr, 32'h0000_2000);
        check("tie1_d_gnt", d_gnt, 1);
        check("tie1_i_gnt", i_gnt, 0);
        d_req = 0;
        step();
        #1;
        check("tie1_rready", bus.rready, 1);
        check("tie1_arvalid_off", bus.arvalid, 0);
        check("tie1_d_gnt_off", d_gnt, 0);
        bus.rvalid = 1; bus.rlast = 1; bus.rdata = 32'hA5A5_0001;
        #1;
        check("tie1_d_rvalid", d_rvalid, 1);
        check("tie1_d_rlast", d_rlast, 1);
        check("tie1_i_rvalid", i_rvalid, 0);
        check("tie1_rd_data", rd_data, 32'hA5A5_0001);
        step();
        bus.rvalid = 0; bus.rlast = 0;
        #1;
        check("tie_gap_rready", bus.rready, 0);
        check("tie_gap_arvalid", bus.arvalid, 0);
        step();
        #1;
        check("tie2_arvalid", bus.arvalid, 1);
        check("tie2_arid", bus.arid, 0);
        check("tie2_araddr", bus.araddr, 32'h0000_1000);
        check("tie2_i_gnt", i_gnt, 1);
        i_req = 0;
        step();
        bus.rvalid = 1; bus.rlast = 1;
        #1;
        check("tie2_i_rvalid", i_rvalid, 1);
        check("tie2_i_rlast", i_rlast, 1);
        check("tie2_d_rvalid", d_rvalid, 0);
        step();
        bus.rvalid = 0; bus.rlast = 0;

        // Four-beat instruction burst with arready held off for 3 cycles
        i_req = 1; i_addr = 32'h0000_3000; i_len = 4'd3; bus.arready = 0;
        step();
        for (int k = 0; k < 4; k++) begin
            if (k == 3) bus.arready = 1;
            #1;
            check("b4_arvalid", bus.arvalid, 1);
            check("b4_araddr", bus.araddr, 32'h0000_3000);
            check("b4_i_gnt", i_gnt, (k == 3) ? 1 : 0);
            if (k == 0) begin
                check("b4_arlen", bus.arlen, 4'd3);
                check("b4_arsize", bus.arsize, 3'b010);
                check("b4_arid", bus.arid, 0);
            end
            if (k == 3) i_req = 0;
            step();
        end
        for (int b = 0; b < 4; b++) begin
            bus.rvalid = 1; bus.rlast = (b == 3); bus.rdata = 32'(b) + 32'h100;
            #1;
            check("b4_i_rvalid", i_rvalid, 1);
            check("b4_i_rlast", i_rlast, (b == 3) ? 1 : 0);
            check("b4_d_rvalid", d_rvalid, 0);
            step();
        end
        bus.rvalid = 0; bus.rlast = 0;

        // Data request withdrawn during the address phase
        d_req = 1; d_addr = 32'h0000_4000; d_len = 4'd1; d_size = 3'b001; bus.arready = 0;
        step();
        d_req = 0;
        #1;
        check("wd_arvalid", bus.arvalid, 1);
        check("wd_arid", bus.arid, 1);
        check("wd_arsize", bus.arsize, 3'b001);
        check("wd_d_gnt_wait", d_gnt, 0);
        step();
        #1 check("wd_araddr_hold", bus.araddr, 32'h0000_4000);
        bus.arready = 1;
        #1 check("wd_d_gnt", d_gnt, 1);
        step();
        bus.rvalid = 1; bus.rlast = 0;
        #1;
        check("wd_beat0", d_rvalid, 1);
        check("wd_beat0_last", d_rlast, 0);
        step();
        // rlast at cycle M; a second data read is already requested
        bus.rlast = 1;
        d_req = 1; d_addr = 32'h0000_5000; d_len = 4'd3; d_size = 3'b010;
        #1;
        check("wd_beat1", d_rvalid, 1);
        check("wd_beat1_last", d_rlast, 1);
        step();
        bus.rvalid = 0; bus.rlast = 0;
        #1;
        check("b2b_m1_arvalid", bus.arvalid, 0);
        check("b2b_m1_rready", bus.rready, 0);
        step();
        #1;
        check("b2b_m2_arvalid", bus.arvalid, 1);
        check("b2b_m2_araddr", bus.araddr, 32'h0000_5000);
        check("b2b_m2_d_gnt", d_gnt, 1);
        d_req = 0;
        step();

        // Reset pulse on beat 2 of 4
        bus.rvalid = 1; bus.rlast = 0;
        #1 check("mr_beat1", d_rvalid, 1);
        step();
        areset = 1;
        #1;
        check("mr_arvalid", bus.arvalid, 0);
        check("mr_rready", bus.rready, 0);
        check("mr_d_rvalid", d_rvalid, 0);
        check("mr_i_rvalid", i_rvalid, 0);
        check("mr_araddr", bus.araddr, 0);
        step();
        areset = 0; bus.rlast = 1;
        #1;
        check("mr_late_d_rvalid", d_rvalid, 0);
        check("mr_late_i_rvalid", i_rvalid, 0);
        check("mr_late_rready", bus.rready, 0);
        step();
        #1;
        check("mr_late2_d_rvalid", d_rvalid, 0);
        check("mr_late2_arvalid", bus.arvalid, 0);
        bus.rvalid = 0; bus.rlast = 0;

        // Fairness with both requests held: D, I, D, I
        i_req = 1; d_req = 1; i_addr = 32'h0000_6000; d_addr = 32'h0000_7000;
        i_len = 0; d_len = 0; bus.arready = 1;
        for (int t = 0; t < 4; t++) begin
            logic exp_d;
            exp_d = (t % 2 == 0);
            step();
            #1;
            check("fair_arid", bus.arid, exp_d ? 32'd1 : 32'd0);
            check("fair_araddr", bus.araddr, exp_d ? 32'h0000_7000 : 32'h0000_6000);
            check("fair_d_gnt", d_gnt, exp_d);
            check("fair_i_gnt", i_gnt, !exp_d);
            step();
            bus.rvalid = 1; bus.rlast = 1;
            #1;
            check("fair_d_rvalid", d_rvalid, exp_d);
            check("fair_i_rvalid", i_rvalid, !exp_d);
            step();
            bus.rvalid = 0; bus.rlast = 0;
        end
        i_req = 0; d_req = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 Parameter ID_I, default 4'd0: arid value driven for instruction-side transactions.
REQ-002 Parameter ID_D, default 4'd1: arid value driven for data-side transactions.
REQ-003 aclk  in  1  sole clock; all state updates on rising edge.
REQ-004 areset  in  1  reset, asynchronous, active-high.
REQ-005 i_req  in  1  instruction-side read request; held until i_gnt.
REQ-006 i_addr  in  32  instruction read address; i_len in 4: beats-1; size fixed 3'b010.
REQ-007 i_gnt  out  1  one-cycle pulse: instruction request accepted on AR channel.
REQ-008 i_rvalid, i_rlast  out  1 each  instruction-side beat valid / last beat.
REQ-009 d_req  in  1  data-side read request; held until d_gnt.
REQ-010 d_addr in 32, d_len in 4, d_size in 3  data-side address, beats-1, beat size.
REQ-011 d_gnt, d_rvalid, d_rlast  out  1 each  data-side equivalents of REQ-007/008.
REQ-012 rd_data  out  32  rdata passed through combinationally, shared by both sides.
REQ-013 arid out 4, araddr out 32, arlen out 4, arsize out 3, arburst out 2, arvalid out 1, arready in 1  AXI read-address channel.
REQ-014 rid in 4, rdata in 32, rresp in 2, rlast in 1, rvalid in 1, rready out 1  AXI read-data channel.

Function
REQ-015 FSM states: IDLE, ADDR, DATA; exactly one AXI read outstanding at any time.
REQ-016 IDLE: if any req is high, pick the winner, latch its addr/len/size/id into registers, and go to ADDR on the next edge.
REQ-017 Arbitration: round-robin; with both reqs high, the side not served last wins; with one req high, that side wins.
REQ-018 The last-served pointer updates at the IDLE->ADDR transition.
REQ-019 ADDR: arvalid=1; araddr/arlen/arsize/arid held stable from the latched registers until arvalid&&arready.
REQ-020 On arvalid&&arready: pulse the owner's gnt in that same cycle and go to DATA.
REQ-021 DATA: rready=1; each rvalid beat is routed to the owner's *_rvalid, and rlast to the owner's *_rlast (combinational, same cycle).
REQ-022 The non-owner's rvalid/rlast stay 0.
REQ-023 DATA: rvalid&&rlast -> IDLE; earliest next arvalid is 2 cycles after the rlast beat.
REQ-024 arburst constantly 2'b01 (INCR).
REQ-025 Instruction-side arsize is always 3'b010.
REQ-026 rresp and rid are not checked; beats are routed by the latched owner only.
REQ-027 A req that drops after being latched does not cancel the transaction; the burst completes and is delivered.
REQ-028 Reqs are ignored in ADDR and DATA; no request queueing.
REQ-029 Latency: req sampled high in IDLE at cycle N -> arvalid high at N+1.
REQ-030 gnt occurs in the arready handshake cycle.
REQ-031 rvalid outside DATA is ignored and rready stays 0.

Reset
REQ-032 areset asserted: state=IDLE immediately, without waiting for a clock edge.
REQ-033 Reset values: arvalid=0, rready=0, all gnt/rvalid/rlast outputs 0.
REQ-034 Reset values: latched addr/len/size/id = 0; last-served pointer = instruction, so data wins the first tie.
REQ-035 Reset mid-ADDR or mid-DATA abandons the transaction; no gnt or beat is delivered afterwards. The AXI slave is reset by the same system reset.
REQ-036 After areset deasserts, the first IDLE evaluation occurs on the next rising edge.

Verification
REQ-037 Tie after reset: i_req=d_req=1 at the same time, arready=1.
-> arid=1, araddr=d_addr, d_gnt pulse.
-> After rlast: arid=0, i_gnt.
REQ-038 Four-beat instruction burst: i_len=3, arready delayed 3 cycles.
-> arvalid and araddr stable for 4 cycles.
-> i_rvalid fires 4 times; i_rlast on beat 4; d_rvalid stays 0.
REQ-039 Back-to-back data reads with i_req low: rlast at cycle M.
-> state IDLE at M+1; arvalid at M+2 with the second d_addr.
REQ-040 Request withdrawn: d_req drops in ADDR.
-> transaction completes; d_rvalid delivers all beats.
REQ-041 areset pulse mid-DATA (beat 2 of 4).
-> arvalid=0, rready=0 and IDLE immediately.
-> Later rvalid produces no i_rvalid/d_rvalid.
REQ-042 Fairness: i_req and d_req both held high continuously.
-> owners alternate D,I,D,I across 4 transactions.
